// File: rtl/bsg_dmc_ui_mux_pkg.sv
// Shared types and helpers for the multi-port DMC UI front end.
package bsg_dmc_ui_mux_pkg;

  typedef enum logic [2:0] {
    WR = 3'b000,
    RD = 3'b001
  } app_cmd_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } ui_mux_state_e;

  // Index width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_dmc_ui_mux_if.sv
// Xilinx-style UI channel bundle; ports_p lanes share one broadcast read-data bus.
interface bsg_dmc_ui_mux_if #(
  parameter int ports_p      = 1,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  localparam int mask_width_lp = data_width_p >> 3;

  logic [ports_p-1:0][addr_width_p-1:0]  app_addr;
  logic [ports_p-1:0][2:0]               app_cmd;
  logic [ports_p-1:0]                    app_en;
  logic [ports_p-1:0]                    app_rdy;
  logic [ports_p-1:0]                    app_wdf_wren;
  logic [ports_p-1:0]                    app_wdf_end;
  logic [ports_p-1:0][data_width_p-1:0]  app_wdf_data;
  logic [ports_p-1:0][mask_width_lp-1:0] app_wdf_mask;
  logic [ports_p-1:0]                    app_wdf_rdy;
  logic [ports_p-1:0]                    app_rd_data_valid;
  logic [ports_p-1:0]                    app_rd_data_end;
  logic [data_width_p-1:0]               app_rd_data;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_rd_data
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_rd_data
  );

endinterface

// File: rtl/bsg_dmc_ui_mux_tagq.sv
// In-order port-ID queue for outstanding reads; full/empty come straight from the count register.
module bsg_dmc_ui_mux_tagq
  import bsg_dmc_ui_mux_pkg::*;
#(
  parameter int width_p = 2,
  parameter int depth_p = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [width_p-1:0] push_data,
  input  logic               pop,
  output logic [width_p-1:0] head,
  output logic               empty,
  output logic               full
);
  localparam int ptr_w_lp = safe_clog2(depth_p);
  localparam logic [ptr_w_lp:0] depth_lp = (ptr_w_lp+1)'(depth_p);

  logic [ptr_w_lp-1:0] wptr_r;
  logic [ptr_w_lp-1:0] rptr_r;
  logic [ptr_w_lp:0]   count_r;
  logic [width_p-1:0]  mem_r [depth_p];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + 1'b1;
      if (pop)  rptr_r <= rptr_r + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_r[wptr_r] <= push_data;
  end

  assign head  = mem_r[rptr_r];
  assign empty = (count_r == '0);
  assign full  = (count_r == depth_lp);

endmodule

// File: rtl/bsg_dmc_ui_mux.sv
// Merges several UI clients onto one DMC app port: round-robin commands, write-burst
// locking, and read-return steering through an in-order port-ID tag queue.
module bsg_dmc_ui_mux
  import bsg_dmc_ui_mux_pkg::*;
#(
  parameter int num_ports_p      = 4,
  parameter int ui_addr_width_p  = 28,
  parameter int ui_data_width_p  = 64,
  parameter int tag_fifo_depth_p = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  bsg_dmc_ui_mux_if.slave       client,
  bsg_dmc_ui_mux_if.master      dmc,
  output logic                  error
);
  localparam int id_width_lp = safe_clog2(num_ports_p);
  localparam logic [id_width_lp-1:0] last_port_lp = id_width_lp'(num_ports_p - 1);

  ui_mux_state_e          state_r, state_n;
  logic [id_width_lp-1:0] ptr_r, ptr_n;
  logic [id_width_lp-1:0] wport_r, wport_n;
  logic                   error_r;

  logic [num_ports_p-1:0] eligible;
  logic [id_width_lp-1:0] winner;
  logic                   have_winner;
  int                     rr_idx;

  logic                   tag_push, tag_pop, tag_empty, tag_full, err_set;
  logic [id_width_lp-1:0] tag_head;

  bsg_dmc_ui_mux_tagq #(
    .width_p (id_width_lp),
    .depth_p (tag_fifo_depth_p)
  ) tagq (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data (winner),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // Round-robin search starting at the priority pointer; reads wait while the tag queue is full.
  always_comb begin
    eligible    = '0;
    winner      = '0;
    have_winner = 1'b0;
    rr_idx      = 0;
    for (int p = 0; p < num_ports_p; p++) begin
      eligible[p] = client.app_en[p] & ~((client.app_cmd[p] == RD) & tag_full);
    end
    for (int i = 0; i < num_ports_p; i++) begin
      rr_idx = (int'(ptr_r) + i) % num_ports_p;
      if (eligible[rr_idx] && !have_winner) begin
        have_winner = 1'b1;
        winner      = id_width_lp'(rr_idx);
      end else begin
        have_winner = have_winner;
      end
    end
  end

  // Next-state and all steering outputs; everything handshake-related is held low in reset.
  always_comb begin
    state_n  = state_r;
    ptr_n    = ptr_r;
    wport_n  = wport_r;
    tag_push = 1'b0;
    tag_pop  = 1'b0;
    err_set  = 1'b0;

    client.app_rdy           = '0;
    client.app_wdf_rdy       = '0;
    client.app_rd_data_valid = '0;
    client.app_rd_data_end   = '0;
    client.app_rd_data       = dmc.app_rd_data;

    dmc.app_en          = 1'b0;
    dmc.app_addr[0]     = client.app_addr[winner];
    dmc.app_cmd[0]      = client.app_cmd[winner];
    dmc.app_wdf_wren    = 1'b0;
    dmc.app_wdf_end[0]  = client.app_wdf_end[wport_r];
    dmc.app_wdf_data[0] = client.app_wdf_data[wport_r];
    dmc.app_wdf_mask[0] = client.app_wdf_mask[wport_r];

    if (reset) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (have_winner) begin
            dmc.app_en[0]          = 1'b1;
            client.app_rdy[winner] = dmc.app_rdy[0];
            if (dmc.app_rdy[0]) begin
              ptr_n = (winner == last_port_lp) ? '0 : winner + 1'b1;
              if (client.app_cmd[winner] == WR) begin
                state_n = WDATA;
                wport_n = winner;
              end else if (client.app_cmd[winner] == RD) begin
                tag_push = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end else begin
              ptr_n = ptr_r;
            end
          end else begin
            ptr_n = ptr_r;
          end
        end
        WDATA: begin
          dmc.app_wdf_wren[0]         = client.app_wdf_wren[wport_r];
          client.app_wdf_rdy[wport_r] = dmc.app_wdf_rdy[0];
          if (client.app_wdf_wren[wport_r] && dmc.app_wdf_rdy[0] && client.app_wdf_end[wport_r]) begin
            state_n = IDLE;
          end else begin
            state_n = WDATA;
          end
        end
        default: state_n = IDLE;
      endcase

      if (dmc.app_rd_data_valid[0]) begin
        if (!tag_empty) begin
          client.app_rd_data_valid[tag_head] = 1'b1;
          client.app_rd_data_end[tag_head]   = dmc.app_rd_data_end[0];
          tag_pop                            = dmc.app_rd_data_end[0];
        end else begin
          err_set = 1'b1;
        end
      end else begin
        tag_pop = 1'b0;
      end
    end
  end

  // State, priority pointer, locked write port and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      wport_r <= '0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      wport_r <= wport_n;
      error_r <= error_r | err_set;
    end
  end

  assign error = error_r;

endmodule
